// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: valid/ready handshake with a two-entry skid buffer,
// flush with selectable data clearing, occupancy output and a saturating stall counter.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | main register holds the head entry
// TWO   | main holds the head, skid holds the next entry, upstream stalled
module pipe_skid_reg #(
  parameter int unsigned CTRL_W              = 11,
  parameter int unsigned DATA_W              = 133,
  parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_next;
  logic [CTRL_W-1:0] main_ctrl, main_ctrl_next;
  logic [DATA_W-1:0] main_data, main_data_next;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_next;
  logic [DATA_W-1:0] skid_data, skid_data_next;
  logic [CNT_W-1:0]  stall_next;
  logic              in_fire;
  logic              out_fire;

  // Ready comes from the state register only, so stalls never ripple combinationally upstream.
  assign in_ready  = reset_n & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = 2'(state);

  always_comb begin
    state_next     = state;
    main_ctrl_next = main_ctrl;
    main_data_next = main_data;
    skid_ctrl_next = skid_ctrl;
    skid_data_next = skid_data;

    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_next     = ONE;
          main_ctrl_next = in_ctrl;
          main_data_next = in_data;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b11: begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end
          2'b10: begin
            state_next     = TWO;
            skid_ctrl_next = in_ctrl;
            skid_data_next = in_data;
          end
          2'b01: state_next = EMPTY;
          default: state_next = ONE;
        endcase
      end
      TWO: begin
        if (out_fire) begin
          state_next     = ONE;
          main_ctrl_next = skid_ctrl;
          main_data_next = skid_data;
        end
      end
      default: state_next = EMPTY;
    endcase

    // Flush turns both slots into bubbles; any same-cycle load above is discarded.
    if (flush) begin
      state_next     = EMPTY;
      main_ctrl_next = '0;
      skid_ctrl_next = '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        main_data_next = '0;
        skid_data_next = '0;
      end else begin
        main_data_next = main_data;
        skid_data_next = skid_data;
      end
    end
  end

  always_comb begin
    stall_next = stall_count;
    if (out_valid && !out_ready && (stall_count != CNT_MAX)) begin
      stall_next = stall_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= EMPTY;
      main_ctrl   <= '0;
      main_data   <= '0;
      skid_ctrl   <= '0;
      skid_data   <= '0;
      stall_count <= '0;
    end else begin
      state       <= state_next;
      main_ctrl   <= main_ctrl_next;
      main_data   <= main_data_next;
      skid_ctrl   <= skid_ctrl_next;
      skid_data   <= skid_data_next;
      stall_count <= stall_next;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a default instance and a hold-data/4-bit-counter instance share
// stimulus; both are compared with a queue-based reference model plus directed tables.
module tb_pipe_skid_reg;

  localparam int CTRL_W = 11;
  localparam int DATA_W = 133;

  logic              clk = 1'b0;
  logic              reset_n, flush, in_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;

  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [15:0]       stall_count;

  logic              in_ready_nc, out_valid_nc;
  logic [CTRL_W-1:0] out_ctrl_nc;
  logic [DATA_W-1:0] out_data_nc;
  logic [1:0]        occupancy_nc;
  logic [3:0]        stall_count_nc;

  always #5 clk = ~clk;

  pipe_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA_ON_FLUSH(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_count(stall_count)
  );

  pipe_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA_ON_FLUSH(1'b0), .CNT_W(4)) dut_nc (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_nc), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_nc), .out_ready(out_ready), .out_ctrl(out_ctrl_nc), .out_data(out_data_nc),
    .occupancy(occupancy_nc), .stall_count(stall_count_nc)
  );

  // Reference model: the stage is a FIFO of at most two entries.
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              q[$];
  logic [DATA_W-1:0] m_clr  = '0;
  logic [DATA_W-1:0] m_hold = '0;
  int                m_stall  = 0;
  int                m_stall4 = 0;
  int                n_tests  = 0;
  int                n_fail   = 0;
  logic              ir_pre;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic rn, input logic fl, input logic iv,
                      input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id, input logic ordy);
    logic exp_ir, ov;
    ent_t e;
    reset_n = rn; flush = fl; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
    #1;
    exp_ir = rn && (q.size() < 2);
    ov     = (q.size() > 0);
    ir_pre = in_ready;
    chk("in_ready", DATA_W'(in_ready), DATA_W'(exp_ir));
    chk("in_ready_nc", DATA_W'(in_ready_nc), DATA_W'(exp_ir));
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_clr = '0; m_hold = '0; m_stall = 0; m_stall4 = 0;
    end else begin
      if (ov && !ordy) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (fl) begin
        q.delete();
        m_clr = '0;
      end else begin
        if (ov && ordy) void'(q.pop_front());
        if (iv && exp_ir) begin
          e.c = ic; e.d = id;
          q.push_back(e);
        end
        if (q.size() > 0) begin
          m_clr  = q[0].d;
          m_hold = q[0].d;
        end
      end
    end
    #1;
    chk("out_valid", DATA_W'(out_valid), DATA_W'(q.size() > 0));
    chk("out_valid_nc", DATA_W'(out_valid_nc), DATA_W'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_ctrl", DATA_W'(out_ctrl), DATA_W'(q[0].c));
      chk("out_ctrl_nc", DATA_W'(out_ctrl_nc), DATA_W'(q[0].c));
    end else begin
      chk("out_ctrl", DATA_W'(out_ctrl), '0);
      chk("out_ctrl_nc", DATA_W'(out_ctrl_nc), '0);
    end
    chk("out_data", out_data, m_clr);
    chk("out_data_nc", out_data_nc, m_hold);
    chk("occupancy", DATA_W'(occupancy), DATA_W'(q.size()));
    chk("occupancy_nc", DATA_W'(occupancy_nc), DATA_W'(q.size()));
    chk("stall_count", DATA_W'(stall_count), DATA_W'(m_stall));
    chk("stall_count_nc", DATA_W'(stall_count_nc), DATA_W'(m_stall4));
  endtask

  typedef struct {
    logic              rn, fl, iv, ordy;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic              e_ir, e_ov;
    logic [CTRL_W-1:0] e_ctrl;
    logic [DATA_W-1:0] e_data;
    logic [1:0]        e_occ;
    int                e_stall;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic iv, input logic ordy, input int val,
                              input logic e_ir, input logic e_ov, input int e_val,
                              input int e_occ, input int e_stall);
    vec_t v;
    v.rn = rn; v.fl = 1'b0; v.iv = iv; v.ordy = ordy;
    v.c = CTRL_W'(val); v.d = DATA_W'(val);
    v.e_ir = e_ir; v.e_ov = e_ov;
    v.e_ctrl = e_ov ? CTRL_W'(e_val) : '0;
    v.e_data = DATA_W'(e_val);
    v.e_occ = 2'(e_occ); v.e_stall = e_stall;
    return v;
  endfunction

  logic [DATA_W-1:0] x1, x2;
  logic [159:0]      rwide;

  initial begin
    vec_t vt[13];
    //            rn iv or  val  ir ov  out occ stall
    vt[0]  = mk(0, 0, 1, 0,    0, 0, 0,   0, 0);
    vt[1]  = mk(0, 0, 1, 0,    0, 0, 0,   0, 0);
    vt[2]  = mk(1, 1, 1, 1,    1, 1, 1,   1, 0);
    vt[3]  = mk(1, 1, 1, 2,    1, 1, 2,   1, 0);
    vt[4]  = mk(1, 1, 1, 3,    1, 1, 3,   1, 0);
    vt[5]  = mk(1, 0, 1, 0,    1, 0, 3,   0, 0);
    vt[6]  = mk(1, 1, 1, 'hA,  1, 1, 'hA, 1, 0);
    vt[7]  = mk(1, 1, 0, 'hB,  1, 1, 'hA, 2, 1);
    vt[8]  = mk(1, 1, 0, 'hC,  0, 1, 'hA, 2, 2);
    vt[9]  = mk(1, 1, 0, 'hC,  0, 1, 'hA, 2, 3);
    vt[10] = mk(1, 1, 1, 'hC,  0, 1, 'hB, 1, 3);
    vt[11] = mk(1, 1, 1, 'hC,  1, 1, 'hC, 1, 3);
    vt[12] = mk(1, 0, 1, 0,    1, 0, 'hC, 0, 3);

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      tick(vt[i].rn, vt[i].fl, vt[i].iv, vt[i].c, vt[i].d, vt[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), DATA_W'(ir_pre), DATA_W'(vt[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), DATA_W'(out_valid), DATA_W'(vt[i].e_ov));
      chk($sformatf("vec%0d_out_ctrl", i), DATA_W'(out_ctrl), DATA_W'(vt[i].e_ctrl));
      chk($sformatf("vec%0d_out_data", i), out_data, vt[i].e_data);
      chk($sformatf("vec%0d_occupancy", i), DATA_W'(occupancy), DATA_W'(vt[i].e_occ));
      chk($sformatf("vec%0d_stall", i), DATA_W'(stall_count), DATA_W'(vt[i].e_stall));
      chk($sformatf("vec%0d_stall_nc", i), DATA_W'(stall_count_nc), DATA_W'(vt[i].e_stall));
    end

    // Flush while full: incoming D is refused and both slots become bubbles.
    x1 = {5{32'hDEAD_BEEF}};
    x2 = {5{32'h1234_5678}};
    tick(1, 0, 1, 11'h7FF, x1, 0);
    tick(1, 0, 1, 11'h123, x2, 0);
    chk("flush_full_occ", DATA_W'(occupancy), DATA_W'(2));
    tick(1, 1, 1, 11'h055, DATA_W'(32'hD), 0);
    chk("flush_out_valid", DATA_W'(out_valid), '0);
    chk("flush_out_ctrl", DATA_W'(out_ctrl), '0);
    chk("flush_out_data", out_data, '0);
    chk("flush_occ", DATA_W'(occupancy), '0);
    chk("flush_nc_out_ctrl", DATA_W'(out_ctrl_nc), '0);
    chk("flush_nc_out_data", out_data_nc, x1);
    tick(1, 0, 0, '0, '0, 1);
    chk("post_flush_in_ready", DATA_W'(ir_pre), DATA_W'(1));
    chk("post_flush_no_d", DATA_W'(out_valid), '0);

    // Flush from ONE with a simultaneous in_fire and out_fire: incoming F is dropped.
    tick(1, 0, 1, 11'h00E, DATA_W'(32'hE), 1);
    tick(1, 1, 1, 11'h00F, DATA_W'(32'hF), 1);
    chk("flush_one_occ", DATA_W'(occupancy), '0);
    chk("flush_one_nc_data", out_data_nc, DATA_W'(32'hE));
    tick(1, 0, 0, '0, '0, 1);
    chk("flush_one_no_f", DATA_W'(out_valid), '0);

    // Stall counter saturation on the 4-bit instance.
    tick(0, 0, 0, '0, '0, 0);
    chk("sat_reset_stall", DATA_W'(stall_count), '0);
    tick(1, 0, 1, 11'h011, DATA_W'(32'h11), 0);
    repeat (20) tick(1, 0, 0, '0, '0, 0);
    chk("sat_stall4", DATA_W'(stall_count_nc), DATA_W'(15));
    chk("sat_stall16", DATA_W'(stall_count), DATA_W'(20));
    tick(1, 1, 0, '0, '0, 0);
    chk("sat_flush_stall4", DATA_W'(stall_count_nc), DATA_W'(15));
    chk("sat_flush_stall16", DATA_W'(stall_count), DATA_W'(21));
    tick(0, 0, 0, '0, '0, 0);
    chk("sat_rst_stall4", DATA_W'(stall_count_nc), '0);
    chk("sat_rst_stall16", DATA_W'(stall_count), '0);

    // Reset while full: X and Y are never emitted.
    tick(1, 0, 1, 11'h0AA, DATA_W'(32'hAA), 0);
    chk("midrst_ready_after", DATA_W'(ir_pre), DATA_W'(1));
    tick(1, 0, 1, 11'h0BB, DATA_W'(32'hBB), 0);
    chk("midrst_full", DATA_W'(occupancy), DATA_W'(2));
    tick(0, 0, 1, 11'h0CC, DATA_W'(32'hCC), 1);
    chk("midrst_ready_low", DATA_W'(ir_pre), '0);
    chk("midrst_out_valid", DATA_W'(out_valid), '0);
    chk("midrst_occ", DATA_W'(occupancy), '0);
    tick(1, 0, 0, '0, '0, 1);
    chk("midrst_ready_high", DATA_W'(ir_pre), DATA_W'(1));
    chk("midrst_no_xy", DATA_W'(out_valid), '0);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 1500; i++) begin
      rwide = {$urandom, $urandom, $urandom, $urandom, $urandom};
      tick(($urandom_range(99) != 0), ($urandom_range(39) == 0), $urandom_range(1) == 1,
           CTRL_W'($urandom), rwide[DATA_W-1:0], $urandom_range(2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
